// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_ctrl
//  Purpose  : Shares the single-port instruction memory between a program
//             loader and the fetch stage. Owns the PC and presents a
//             registered {pc_f, instr_f, instr_valid} bundle to decode.
//  Revision : 1.0  initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              stall_f,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pc_f,
  output logic [31:0]       instr_f,
  output logic              instr_valid,
  output logic              running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] c_pc_step    = 32'd4;
  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_f;
  logic        r_instr_valid;

  logic        w_in_load;

  assign w_in_load = (r_state == S_LOAD);

  // Memory port mux: loader owns the port only while in LOAD.
  assign ld_ready  = w_in_load;
  assign mem_we    = w_in_load & ld_valid;
  assign mem_addr  = w_in_load ? ld_addr : r_pc[ADDR_W+1:2];
  assign mem_wdata = ld_data;

  assign pc_f        = r_pc_f;
  assign instr_f     = r_instr_f;
  assign instr_valid = r_instr_valid;
  assign running     = (r_state == S_RUN);

  // Sequencer FSM, PC and registered fetch bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pc_f        <= 32'd0;
      r_instr_f     <= 32'd0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc          <= RESET_PC;
          r_instr_valid <= 1'b0;
          r_state       <= load_en ? S_LOAD : S_RUN;
        end
        S_LOAD: begin
          r_instr_valid <= 1'b0;
          if (!load_en) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
          end
        end
        S_RUN: begin
          if (load_en) begin
            r_state       <= S_LOAD;
            r_instr_valid <= 1'b0;
          end else if (redirect_en) begin
            // Redirect wins over stall; low address bits are silently dropped.
            r_pc          <= redirect_pc & c_align_mask;
            r_instr_valid <= 1'b0;
          end else if (!stall_f) begin
            r_pc_f        <= r_pc;
            r_instr_f     <= mem_rdata;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + c_pc_step;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_fetch_ctrl
//  Purpose  : Directed vector bench for imem_fetch_ctrl with a behavioural
//             combinational-read instruction memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  typedef struct {
    logic        le;
    logic        lv;
    logic [9:0]  la;
    logic [31:0] ld;
    logic        st;
    logic        rd;
    logic [31:0] rp;
    logic        e_we;
    logic        e_run;
    logic        e_rdy;
    logic        e_v;
    logic        cb;
    logic [31:0] e_pc;
    logic [31:0] e_in;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 : ADDR_W = 10 ----------------
  logic        rst, load_en, ld_valid, ld_ready, stall_f, redirect_en;
  logic [9:0]  ld_addr, mem_addr;
  logic [31:0] ld_data, redirect_pc, mem_wdata, mem_rdata, pc_f, instr_f;
  logic        mem_we, instr_valid, running;
  logic [31:0] mem1 [1024];

  imem_fetch_ctrl #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .stall_f(stall_f), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pc_f(pc_f), .instr_f(instr_f),
    .instr_valid(instr_valid), .running(running)
  );

  always @(posedge clk) if (mem_we) mem1[mem_addr] <= mem_wdata;
  assign mem_rdata = mem1[mem_addr];

  // ---------------- DUT 2 : ADDR_W = 2 (wrap) ----------------
  logic        rst2, le2, lv2, ready2, we2, valid2, run2;
  logic        stall2, redir2;
  logic [1:0]  la2, maddr2;
  logic [31:0] ld2, rpc2, wdata2, rdata2, pcf2, instr2;
  logic [31:0] mem2 [4];

  imem_fetch_ctrl #(.ADDR_W(2), .RESET_PC(32'h0)) dut2 (
    .clk(clk), .rst(rst2), .load_en(le2), .ld_valid(lv2),
    .ld_ready(ready2), .ld_addr(la2), .ld_data(ld2),
    .stall_f(stall2), .redirect_en(redir2), .redirect_pc(rpc2),
    .mem_we(we2), .mem_addr(maddr2), .mem_wdata(wdata2),
    .mem_rdata(rdata2), .pc_f(pcf2), .instr_f(instr2),
    .instr_valid(valid2), .running(run2)
  );

  always @(posedge clk) if (we2) mem2[maddr2] <= wdata2;
  assign rdata2 = mem2[maddr2];

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];
  logic [31:0] prog [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t f_ld(input logic le, input logic lv, input logic [9:0] a,
                                input logic [31:0] d, input logic ewe,
                                input logic erun, input logic erdy);
    vec_t v;
    v = '{le:le, lv:lv, la:a, ld:d, st:1'b0, rd:1'b0, rp:32'h0, e_we:ewe,
          e_run:erun, e_rdy:erdy, e_v:1'b0, cb:1'b0, e_pc:32'h0, e_in:32'h0};
    return v;
  endfunction

  function automatic vec_t f_run(input logic st, input logic rd, input logic [31:0] rp,
                                 input logic ev, input logic cb,
                                 input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v = '{le:1'b0, lv:1'b0, la:10'h0, ld:32'h0, st:st, rd:rd, rp:rp, e_we:1'b0,
          e_run:1'b1, e_rdy:1'b0, e_v:ev, cb:cb, e_pc:epc, e_in:ei};
    return v;
  endfunction

  initial begin
    prog = '{32'h00500293, 32'h00300313, 32'h006283B3, 32'h00002403,
             32'h00100493, 32'h00940533, 32'h00940533};

    // Boot load: IDLE->LOAD, seven writes, then release load_en.
    vecs.push_back(f_ld(1'b1, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 7; k++)
      vecs.push_back(f_ld(1'b1, 1'b1, 10'(k), prog[k], 1'b1, 1'b0, 1'b1));
    vecs.push_back(f_ld(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 1'b0));
    // Stream words 0..2, stall 3 cycles at pc_f = 8, then words 3..6.
    for (int k = 0; k < 3; k++)
      vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(4 * k), prog[k]));
    for (int k = 0; k < 3; k++)
      vecs.push_back(f_run(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'd8, prog[2]));
    for (int k = 3; k < 7; k++)
      vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(4 * k), prog[k]));
    // Redirect together with stall to misaligned 0x6: one bubble, then pc 4.
    vecs.push_back(f_run(1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd4, prog[1]));
    // Re-load mid-run; the write offered in the RUN cycle must be ignored,
    // the write offered on the LOAD exit cycle must land.
    vecs.push_back(f_ld(1'b1, 1'b1, 10'd1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
    vecs.push_back(f_ld(1'b1, 1'b1, 10'd0, 32'h00000013, 1'b1, 1'b0, 1'b1));
    vecs.push_back(f_ld(1'b0, 1'b1, 10'd2, 32'h00000093, 1'b1, 1'b1, 1'b0));
    vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd0, 32'h00000013));
    vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd4, prog[1]));
    vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd8, 32'h00000093));
    // Plain redirect to misaligned 0x17 -> 0x14.
    vecs.push_back(f_run(1'b0, 1'b1, 32'h17, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(f_run(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, prog[5]));
    // Back into LOAD for the async reset sequence.
    vecs.push_back(f_ld(1'b1, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1));

    rst = 1'b1; load_en = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    stall_f = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    rst2 = 1'b1; le2 = 1'b0; lv2 = 1'b0; la2 = '0; ld2 = '0;
    stall2 = 1'b0; redir2 = 1'b0; rpc2 = '0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("rst.pc_f", pc_f, 32'h0);
    chk("rst.instr_f", instr_f, 32'h0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.ready", {31'd0, ld_ready}, 32'd0);
    chk("rst.we", {31'd0, mem_we}, 32'd0);
    chk("rst.running", {31'd0, running}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      load_en = vecs[i].le; ld_valid = vecs[i].lv; ld_addr = vecs[i].la;
      ld_data = vecs[i].ld; stall_f = vecs[i].st; redirect_en = vecs[i].rd;
      redirect_pc = vecs[i].rp;
      #1;
      chk($sformatf("v%0d.mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
      @(posedge clk); #1;
      chk($sformatf("v%0d.running", i), {31'd0, running}, {31'd0, vecs[i].e_run});
      chk($sformatf("v%0d.ld_ready", i), {31'd0, ld_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d.valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_v});
      if (vecs[i].cb) begin
        chk($sformatf("v%0d.pc_f", i), pc_f, vecs[i].e_pc);
        chk($sformatf("v%0d.instr_f", i), instr_f, vecs[i].e_in);
      end
      @(negedge clk);
    end

    // Async reset pulse between edges in LOAD with a write pending.
    load_en = 1'b1; ld_valid = 1'b1; ld_addr = 10'd3; ld_data = 32'hFFFF_FFFF;
    #1; rst = 1'b1;
    #1;
    chk("arst.pc_f", pc_f, 32'h0);
    chk("arst.instr_f", instr_f, 32'h0);
    chk("arst.valid", {31'd0, instr_valid}, 32'd0);
    chk("arst.ready", {31'd0, ld_ready}, 32'd0);
    chk("arst.we", {31'd0, mem_we}, 32'd0);
    chk("arst.running", {31'd0, running}, 32'd0);
    #1; rst = 1'b0; load_en = 1'b0;
    @(posedge clk); #1;
    chk("arst.idle_to_run", {31'd0, running}, 32'd1);
    chk("arst.valid_e1", {31'd0, instr_valid}, 32'd0);
    ld_valid = 1'b0;
    chk("arst.no_write", mem1[3], prog[3]);
    @(posedge clk); #1;
    chk("arst.valid_e2", {31'd0, instr_valid}, 32'd1);
    chk("arst.pc_f_e2", pc_f, 32'h0);
    chk("arst.instr_e2", instr_f, 32'h00000013);
    @(negedge clk);

    // Wrap with a 4-word memory.
    rst2 = 1'b0; le2 = 1'b1;
    @(posedge clk); #1;
    chk("wrap.ready", {31'd0, ready2}, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      lv2 = 1'b1; la2 = 2'(k); ld2 = 32'hA0A0_0000 + 32'(k);
      @(posedge clk); @(negedge clk);
    end
    le2 = 1'b0; lv2 = 1'b0;
    @(posedge clk); #1;
    chk("wrap.running", {31'd0, run2}, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap%0d.pc_f", k), pcf2, 32'(4 * k));
      chk($sformatf("wrap%0d.instr_f", k), instr2, 32'hA0A0_0000 + 32'(k % 4));
      chk($sformatf("wrap%0d.valid", k), {31'd0, valid2}, 32'd1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and arbiter for the single-port, combinational-read instruction memory. It shares the memory's one address port between a program loader, which writes words through a valid/ready handshake, and the pipeline fetch stage. It owns the PC and presents a registered {pc_f, instr_f, instr_valid} bundle to the decode stage. Stall and branch/jump redirect requests from the pipeline are honoured on a cycle-exact basis.

## Interface
Parameters:
- ADDR_W, 10: word-address width of the instruction memory (1024 words).
- RESET_PC, 32'h0000_0000: PC loaded on reset and on every LOAD→RUN transition.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  level; 1 requests loader ownership of the memory.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle when ld_valid is also 1.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  32  loader write data.
- stall_f  in  1  hold the fetch bundle and PC.
- redirect_en  in  1  branch/jump taken; load PC from redirect_pc.
- redirect_pc  in  32  byte address of the redirect target.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- pc_f  out  32  PC of instr_f.
- instr_f  out  32  fetched instruction.
- instr_valid  out  1  fetch bundle is valid.
- running  out  1  1 while in RUN.

## Operation
FSM with states IDLE, LOAD and RUN. Reset enters IDLE.
- IDLE: for one cycle, go to LOAD if load_en = 1, else go to RUN. pc ← RESET_PC.
- LOAD:
  - ld_ready = 1 (combinational).
  - mem_we = ld_valid, mem_addr = ld_addr, mem_wdata = ld_data.
  - instr_valid is held at 0.
  - If load_en = 0 at a clock edge, go to RUN and set pc ← RESET_PC. The write in that same cycle still completes if ld_valid = 1.
- RUN:
  - ld_ready = 0, mem_we = 0, mem_addr = pc[ADDR_W+1:2].
  - Per edge, in priority order:
    1. load_en = 1: go to LOAD, instr_valid ← 0.
    2. redirect_en = 1: pc ← {redirect_pc[31:2], 2'b00}, instr_valid ← 0. Redirect overrides stall.
    3. stall_f = 1: pc, pc_f, instr_f and instr_valid hold.
    4. Otherwise: pc_f ← pc, instr_f ← mem_rdata, instr_valid ← 1, pc ← pc + 4.
- PC arithmetic is 32-bit modulo 2^32. The memory index takes only pc[ADDR_W+1:2], so fetch wraps to word 0 after word 2^ADDR_W − 1.
- Misaligned redirect targets have bits [1:0] forced to 0; no fault is raised.
- running = (state == RUN).

## Timing
- Reset values: pc = RESET_PC, pc_f = 0, instr_f = 0, instr_valid = 0, state = IDLE. ld_ready = 0, mem_we = 0, running = 0.
- Fetch latency: the instruction at address pc appears on instr_f one edge after pc is driven; throughput is 1 word per cycle.
- First valid instruction after IDLE→RUN: instr_valid rises 2 edges after reset release (IDLE, then RUN).
- Redirect: redirect asserted at edge N leaves exactly one bubble (instr_valid = 0 after N). The target instruction is valid after edge N+1.
- Loader handshake: a write occurs on every edge with ld_valid & ld_ready. There is no backpressure inside LOAD.
- Reset is asynchronous and may arrive mid-load or mid-run. All registers clear immediately, and any in-flight write is dropped if rst is asserted before the edge.
- load_en asserted in RUN takes effect at the next edge. Writes are only accepted from the cycle LOAD is entered.

## Test plan
- Boot load:
  - Stimulus: load_en = 1; write words 0..6 = 00500293, 00300313, 006283B3, 00002403, 00100493, 00940533, 00940533; drop load_en.
  - Required response: instr_f streams those 7 words on consecutive cycles with pc_f = 0, 4, …, 24, and instr_valid = 1 throughout.
- Stall:
  - Stimulus: assert stall_f for 3 cycles while pc_f = 8.
  - Required response: pc_f = 8, instr_f = 006283B3 and instr_valid = 1 are held for 3 cycles; pc_f = 12 follows.
- Redirect vs. stall:
  - Stimulus: redirect_en = 1 and stall_f = 1 together, redirect_pc = 32'h6.
  - Required response: one bubble, then pc_f = 4 with instr_f = 00300313.
- Wrap:
  - Stimulus: ADDR_W = 2, RUN from RESET_PC.
  - Required response: pc_f = 0, 4, 8, 12, 16 fetches memory words 0, 1, 2, 3, 0.
- Re-load mid-run:
  - Stimulus: assert load_en while running; write word 0 = 00000013; release load_en.
  - Required response: instr_valid drops to 0 the edge after load_en is asserted; after release, pc_f = 0 with instr_f = 00000013.
- Async reset:
  - Stimulus: pulse rst between edges during LOAD with ld_valid = 1.
  - Required response: outputs reach their reset values immediately, no memory write occurs, and the block restarts in IDLE.
